// File: rtl/sprinkler_system.sv
// Sprinkler controller: loads (zone, start, stop) windows from the SD reader, then drives four
// valves from GPS time and the rain sensor. Optional macro RAIN_HOLDOFF_EN adds a post-rain delay.
module sprinkler_system #(
  parameter int unsigned MAX_ENTRIES         = 8,
  parameter int unsigned RAIN_HOLDOFF_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gps_time_reg,
  input  logic        gps_data_valid,
  input  logic        raining,
  output logic        SD_read_next_line,
  input  logic        SD_data_valid,
  input  logic [1:0]  SD_zones,
  input  logic [31:0] SD_start_time,
  input  logic [31:0] SD_stop_time,
  output logic        zone_0,
  output logic        zone_1,
  output logic        zone_2,
  output logic        zone_3
);

  localparam int unsigned CountW = $clog2(MAX_ENTRIES + 1);
  localparam int unsigned IdxW   = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;

  typedef enum logic [1:0] {StLoadReq, StLoadWait, StLoadGap, StRun} state_e;

  state_e            state_q;
  logic [CountW-1:0] count_q;
  logic [1:0]        tbl_zone_q  [MAX_ENTRIES];
  logic [31:0]       tbl_start_q [MAX_ENTRIES];
  logic [31:0]       tbl_stop_q  [MAX_ENTRIES];
  logic [31:0]       cur_time_q;
  logic              time_valid_q;
  logic [3:0]        zone_q, zone_d, zone_hit;
  logic              rain_block;
  logic [IdxW-1:0]   wr_idx;

  assign wr_idx = IdxW'(count_q);

  // ASCII "HHMM" digits compare correctly as plain unsigned words.
  function automatic logic win_match(logic [31:0] start, logic [31:0] stop, logic [31:0] t);
    if (start < stop)      return (t >= start) && (t < stop);
    else if (start > stop) return (t >= start) || (t < stop);
    else                   return 1'b0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StLoadReq;
      SD_read_next_line <= 1'b0;
      count_q           <= '0;
      for (int i = 0; i < MAX_ENTRIES; i++) begin
        tbl_zone_q[i]  <= '0;
        tbl_start_q[i] <= '0;
        tbl_stop_q[i]  <= '0;
      end
    end else begin
      SD_read_next_line <= 1'b0;
      unique case (state_q)
        StLoadReq: begin
          SD_read_next_line <= 1'b1;
          state_q           <= StLoadWait;
        end
        StLoadWait: begin
          if (SD_data_valid) begin
            if (SD_start_time == '0 && SD_stop_time == '0) begin
              state_q <= StRun;
            end else begin
              tbl_zone_q[wr_idx]  <= SD_zones;
              tbl_start_q[wr_idx] <= SD_start_time;
              tbl_stop_q[wr_idx]  <= SD_stop_time;
              count_q             <= count_q + 1'b1;
              state_q             <= StLoadGap;
            end
          end
        end
        StLoadGap: begin
          if (!SD_data_valid) begin
            state_q <= (count_q == CountW'(MAX_ENTRIES)) ? StRun : StLoadReq;
          end
        end
        StRun: state_q <= StRun;
        default: state_q <= StLoadReq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_time_q   <= '0;
      time_valid_q <= 1'b0;
    end else if (gps_data_valid) begin
      cur_time_q   <= gps_time_reg;
      time_valid_q <= 1'b1;
    end
  end

`ifdef RAIN_HOLDOFF_EN
  logic [31:0] holdoff_q;

  // Reloads while raining, so the delay counts from the last rainy clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdoff_q <= '0;
    end else if (raining) begin
      holdoff_q <= RAIN_HOLDOFF_CYCLES;
    end else if (holdoff_q != '0) begin
      holdoff_q <= holdoff_q - 32'd1;
    end
  end

  assign rain_block = raining | (holdoff_q != '0);
`else
  assign rain_block = raining;
`endif

  always_comb begin
    zone_hit = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if ((CountW'(i) < count_q) && win_match(tbl_start_q[i], tbl_stop_q[i], cur_time_q)) begin
        zone_hit[tbl_zone_q[i]] = 1'b1;
      end
    end
    zone_d = '0;
    if (state_q == StRun && time_valid_q && !rain_block) begin
      zone_d = zone_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zone_q <= '0;
    end else begin
      zone_q <= zone_d;
    end
  end

  assign zone_0 = zone_q[0];
  assign zone_1 = zone_q[1];
  assign zone_2 = zone_q[2];
  assign zone_3 = zone_q[3];

endmodule

// File: tb/tb_sprinkler_system.sv
// Bench for sprinkler_system: SD-card responder, GPS/rain stimulus and a minutes-based window model.
module tb_sprinkler_system;
  localparam int unsigned MAX  = 8;
  localparam int unsigned HOLD = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gps_time_reg;
  logic        gps_data_valid;
  logic        raining;
  logic        SD_read_next_line;
  logic        SD_data_valid;
  logic [1:0]  SD_zones;
  logic [31:0] SD_start_time;
  logic [31:0] SD_stop_time;
  logic        zone_0, zone_1, zone_2, zone_3;
  logic [3:0]  zones;

  assign zones = {zone_3, zone_2, zone_1, zone_0};

  always #5 clk = ~clk;

  sprinkler_system #(
    .MAX_ENTRIES        (MAX),
    .RAIN_HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .gps_time_reg     (gps_time_reg),
    .gps_data_valid   (gps_data_valid),
    .raining          (raining),
    .SD_read_next_line(SD_read_next_line),
    .SD_data_valid    (SD_data_valid),
    .SD_zones         (SD_zones),
    .SD_start_time    (SD_start_time),
    .SD_stop_time     (SD_stop_time),
    .zone_0           (zone_0),
    .zone_1           (zone_1),
    .zone_2           (zone_2),
    .zone_3           (zone_3)
  );

  int checks = 0;
  int errors = 0;
  int pulse_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) pulse_cnt <= 0;
    else if (SD_read_next_line) pulse_cnt <= pulse_cnt + 1;
  end

  typedef struct {
    logic [1:0]  z;
    logic [31:0] s;
    logic [31:0] e;
  } ent_t;

  ent_t        lines[$];
  ent_t        model[$];
  logic [31:0] cur_t;
  bit          t_valid;
  bit          in_run;

  function automatic logic [31:0] hhmm(int h, int m);
    return {8'(48 + h / 10), 8'(48 + h % 10), 8'(48 + m / 10), 8'(48 + m % 10)};
  endfunction

  function automatic int mins(logic [31:0] a);
    int h, m;
    h = (int'(a[31:24]) - 48) * 10 + (int'(a[23:16]) - 48);
    m = (int'(a[15:8]) - 48) * 10 + (int'(a[7:0]) - 48);
    return h * 60 + m;
  endfunction

  // Expected valves from the stored schedule, evaluated in minutes of the day.
  function automatic logic [3:0] expect_zones(bit rain);
    logic [3:0] r = '0;
    int s, e, t;
    if (!in_run || !t_valid || rain) return '0;
    t = mins(cur_t);
    foreach (model[i]) begin
      s = mins(model[i].s);
      e = mins(model[i].e);
      if ((s < e && t >= s && t < e) || (s > e && (t >= s || t < e))) r[model[i].z] = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    gps_data_valid = 1'b0;
    gps_time_reg   = '0;
    raining        = 1'b0;
    SD_data_valid  = 1'b0;
    SD_zones       = '0;
    SD_start_time  = '0;
    SD_stop_time   = '0;
    repeat (2) @(negedge clk);
    check("reset_req", 32'(SD_read_next_line), 0);
    check("reset_zones", 32'(zones), 0);
    rst     = 1'b0;
    t_valid = 1'b0;
    in_run  = 1'b0;
  endtask

  // Answers n request pulses from lines[], then one end marker if asked.
  task automatic serve(input int n, input bit marker);
    bit got;
    for (int i = 0; i < n + int'(marker); i++) begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        got = SD_read_next_line;
      end
      check("req_seen", 32'(got), 1);
      if (!got) return;
      SD_data_valid = 1'b1;
      if (i < n) begin
        SD_zones      = lines[i].z;
        SD_start_time = lines[i].s;
        SD_stop_time  = lines[i].e;
      end else begin
        SD_zones      = '0;
        SD_start_time = '0;
        SD_stop_time  = '0;
      end
      @(negedge clk);
      SD_data_valid = 1'b0;
      check("req_width", 32'(SD_read_next_line), 0);
    end
  endtask

  task automatic set_time(input logic [31:0] t);
    logic [3:0] old_z;
    old_z          = expect_zones(raining);
    gps_time_reg   = t;
    gps_data_valid = 1'b1;
    @(negedge clk);
    gps_data_valid = 1'b0;
    cur_t          = t;
    t_valid        = 1'b1;
    check("zone_latency", 32'(zones), 32'(old_z));
    @(negedge clk);
    check("zone_model", 32'(zones), 32'(expect_zones(raining)));
  endtask

  initial begin
    logic [31:0] bnd[9];
    logic [31:0] t;
    bnd = '{hhmm(6, 0), hhmm(6, 30), hhmm(23, 0), hhmm(1, 0), hhmm(8, 0),
            hhmm(12, 0), hhmm(13, 0), hhmm(23, 59), hhmm(0, 0)};
    rst = 1'b1;
    do_reset();

    // Two entries plus end marker: three request pulses, then RUN.
    lines = '{'{2'd0, hhmm(6, 0), hhmm(6, 30)}, '{2'd2, hhmm(12, 0), hhmm(13, 0)}};
    model = lines;
    serve(2, 1'b1);
    check("req_pulses_3", pulse_cnt, 3);
    repeat (6) @(negedge clk);
    check("no_extra_req", pulse_cnt, 3);
    in_run = 1'b1;
    check("no_time_yet", 32'(zones), 0);

    set_time(32'h30363135);
    check("t_0615", 32'(zones), 32'b0001);
    set_time(hhmm(6, 30));
    check("t_0630_excl", 32'(zones), 0);
    set_time(hhmm(12, 59));
    check("t_1259", 32'(zones), 32'b0100);

    raining = 1'b1;
    @(negedge clk);
    check("rain_on", 32'(zones), 0);
    raining = 1'b0;
    @(negedge clk);
`ifdef RAIN_HOLDOFF_EN
    check("holdoff_active", 32'(zones), 0);
    repeat (HOLD + 2) @(negedge clk);
    check("holdoff_done", 32'(zones), 32'b0100);
`else
    check("rain_off", 32'(zones), 32'b0100);
`endif

    // Reset mid-run, reload with an over-midnight and a zero-length window.
    do_reset();
    lines = '{'{2'd0, hhmm(6, 0), hhmm(6, 30)}, '{2'd3, hhmm(23, 0), hhmm(1, 0)},
              '{2'd1, hhmm(8, 0), hhmm(8, 0)}, '{2'd2, hhmm(12, 0), hhmm(13, 0)}};
    model = lines;
    serve(4, 1'b1);
    check("req_pulses_5", pulse_cnt, 5);
    in_run = 1'b1;
    set_time(hhmm(23, 30));
    check("t_2330", 32'(zones), 32'b1000);
    set_time(hhmm(0, 30));
    check("t_0030", 32'(zones), 32'b1000);
    set_time(hhmm(1, 0));
    check("t_0100", 32'(zones), 0);
    set_time(hhmm(8, 0));
    check("t_0800_empty", 32'(zones), 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) t = bnd[$urandom_range(0, 8)];
      else t = hhmm(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
`ifdef RAIN_HOLDOFF_EN
      raining = 1'b0;
`else
      raining = ($urandom_range(0, 3) == 0);
`endif
      set_time(t);
    end
    raining = 1'b0;

    // Partial load, zones held off while loading, then reset mid-load.
    do_reset();
    lines.delete();
    for (int i = 0; i < int'(MAX); i++) lines.push_back('{2'(i % 4), hhmm(i + 1, 0), hhmm(i + 1, 30)});
    model = lines;
    serve(3, 1'b0);
    set_time(hhmm(1, 15));
    check("load_zones_off", 32'(zones), 0);
    do_reset();
    serve(int'(MAX), 1'b0);
    check("req_pulses_max", pulse_cnt, int'(MAX));
    repeat (6) @(negedge clk);
    check("no_req_after_max", pulse_cnt, int'(MAX));
    in_run = 1'b1;
    check("tvalid_cleared", 32'(zones), 0);
    set_time(hhmm(8, 10));
    check("last_entry", 32'(zones), 32'b1000);
    set_time(hhmm(5, 15));
    check("entry_4", 32'(zones), 32'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
